mig_tt_evaluator: RTL and testbench
===================================

Name: mig_tt_evaluator

Overview:
- Programmable majority-inverter-graph (MIG) evaluator. Computes the full truth table of a candidate network of 3-input majority nodes with complemented edges over NUM_IN primary inputs.
- Evaluates one node per cycle, using a bitwise majority over 2^NUM_IN-bit truth-table vectors.
- Sits beside the exact-synthesis flow as the hardware checker for generated MAJ-chain netlists. It compares the result against a target function.

Parameters:
- NUM_IN, 4, number of primary inputs; truth-table width TT_W = 2^NUM_IN.
- MAX_NODES, 8, node-program depth.
- SEL_W, clog2(1+NUM_IN+MAX_NODES), operand selector width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  node-program write strobe.
- cfg_addr  in  clog2(MAX_NODES)  node index to write.
- cfg_data  in  3*(SEL_W+1)  operands a,b,c; a in the LSBs. Each operand is {inv, sel}.
- num_nodes  in  clog2(MAX_NODES+1)  active node count, sampled on start.
- out_sel  in  SEL_W  output signal selector, sampled on start.
- out_inv  in  1  output complement, sampled on start.
- target  in  TT_W  reference truth table, sampled on start.
- start  in  1  begin evaluation (one-cycle pulse).
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle completion pulse.
- tt_out  out  TT_W  resulting truth table.
- match  out  1  tt_out == captured target.
- err  out  1  illegal program detected.

Behaviour:
- Selector encoding: 0 = constant 0; 1..NUM_IN = input x(sel-1); NUM_IN+1+k = node k.
  - Input projection: bit m of x_j = bit j of m. For NUM_IN=4: x0=0xAAAA, x1=0xCCCC, x2=0xF0F0, x3=0xFF00.
  - inv=1 complements the selected vector; for constant 0 this gives all-ones.
- Node k = bitwise MAJ(a,b,c) = (a&b)|(a&c)|(b&c), stored in node register k (TT_W bits).
- Program RAM: MAX_NODES entries. Written when cfg_we=1 and not busy. Writes while busy are ignored. cfg_addr >= MAX_NODES is ignored. Contents are undefined after reset until written.
- FSM IDLE -> EVAL -> DONE -> IDLE.
  - IDLE: on start, capture num_nodes (saturated to MAX_NODES), out_sel, out_inv and target. Clear node index. busy=1 next cycle.
  - If captured num_nodes=0, go directly to DONE.
  - EVAL: one node per cycle. Node i may reference only constant, inputs, or node j<i.
    - A reference to j>=i, or to a selector beyond NUM_IN+MAX_NODES, sets err=1 and goes to DONE.
    - After node num_nodes-1, go to DONE.
  - DONE: drive done=1 for one cycle. Update tt_out = selected vector ^ {TT_W{out_inv}} and set match. Clear busy. Return to IDLE.
  - out_sel referencing node >= num_nodes sets err=1.
  - On err, tt_out=0 and match=0.
- Latency: start sampled at edge t; done asserted during cycle t+N+1, where N = captured num_nodes.
- tt_out, match and err hold until the next DONE. err clears on the next start.
- start while busy: ignored. start in the same cycle as cfg_we: the write commits first, so evaluation sees the new entry.
- Reset (async, any state): FSM=IDLE; busy, done, match, err = 0; tt_out=0; node registers cleared. An operation in flight is discarded, and no done is issued.

Test Plan:
- Single node: MAJ(x0,x1,x2), out_sel=node0, N=1 -> done at start+2, tt_out=0xE8E8, busy high exactly 2 cycles.
- AND/OR via constants: MAJ(x0,x1,0) -> 0x8888. MAJ(x0,x1,~0) -> 0xEEEE. With target=0xEEEE, match=1.
- XOR, 3 nodes: n0=MAJ(x0,~x1,0)=0x2222, n1=MAJ(~x0,x1,0)=0x4444, n2=MAJ(n0,n1,~0) -> tt_out=0x6666. With out_inv=1 -> 0x9999. done at start+4.
- Zero nodes: N=0, out_sel=x3, out_inv=1 -> tt_out=0x00FF, done at start+1. N=0 with out_sel=node0 -> err=1, tt_out=0.
- Illegal forward reference: node1 operand selects node1 -> err=1, done asserted, match=0. The next legal start clears err.
- Reset and ignore rules:
  - Assert rst_n=0 mid-EVAL of an 8-node program -> busy/done/tt_out read 0 immediately, and no done pulse follows.
  - cfg_we or start during busy -> no effect on the result.

Source files
------------

// File: rtl/mig_tt_evaluator.sv
// rtl/mig_tt_evaluator.sv - programmable MIG truth-table evaluator, one majority node per cycle
module mig_tt_evaluator #(
    parameter  int NUM_IN    = 4,
    parameter  int MAX_NODES = 8,
    localparam int TT_W      = 1 << NUM_IN,
    localparam int SEL_W     = $clog2(1 + NUM_IN + MAX_NODES),
    localparam int AW        = $clog2(MAX_NODES),
    localparam int NW        = $clog2(MAX_NODES + 1),
    localparam int OP_W      = SEL_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [3*OP_W-1:0] cfg_data,
    input  logic [NW-1:0]     num_nodes,
    input  logic [SEL_W-1:0]  out_sel,
    input  logic              out_inv,
    input  logic [TT_W-1:0]   target,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt_out,
    output logic              match,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [NW-1:0]                 idx_q, idx_d;
    logic [NW-1:0]                 n_q, n_d;
    logic [SEL_W-1:0]              osel_q, osel_d;
    logic                          oinv_q, oinv_d;
    logic [TT_W-1:0]               target_q, target_d;
    logic [MAX_NODES-1:0][TT_W-1:0] node_q, node_d;
    logic [TT_W-1:0]               tt_q, tt_d;
    logic                          match_q, match_d;
    logic                          err_q, err_d;
    logic [3*OP_W-1:0]             prog_q [MAX_NODES];

    // Projection vector of input j: bit m is bit j of m.
    function automatic logic [TT_W-1:0] proj(input int j);
        logic [TT_W-1:0] v;
        for (int m = 0; m < TT_W; m++) v[m] = ((m >> j) & 1) == 1;
        return v;
    endfunction

    // Uncomplemented vector for a selector; unknown selectors read as zero.
    function automatic logic [TT_W-1:0] sel_vec(input logic [SEL_W-1:0] sel,
                                                input logic [MAX_NODES-1:0][TT_W-1:0] nodes);
        logic [TT_W-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_IN; j++) if (int'(sel) == j + 1) v = proj(j);
        for (int k = 0; k < MAX_NODES; k++) if (int'(sel) == NUM_IN + 1 + k) v = nodes[k];
        return v;
    endfunction

    // A selector is legal if it names the constant, an input, or a node below lim.
    function automatic logic sel_ok(input logic [SEL_W-1:0] sel, input logic [NW-1:0] lim);
        int s;
        s = int'(sel);
        if (s <= NUM_IN) return 1'b1;
        if (s > NUM_IN + MAX_NODES) return 1'b0;
        return (s - NUM_IN - 1) < int'(lim);
    endfunction

    logic [3*OP_W-1:0] entry;
    logic [OP_W-1:0]   op_a, op_b, op_c;
    logic [TT_W-1:0]   va, vb, vc, maj, fin_v;
    logic              ops_ok, finish;
    logic [NW-1:0]     sat_n, f_n;
    logic [SEL_W-1:0]  f_sel;
    logic              f_inv;
    logic [TT_W-1:0]   f_tgt;

    // Program RAM: no reset, writes only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && int'(cfg_addr) < MAX_NODES) prog_q[cfg_addr] <= cfg_data;
    end

    // Next-state logic: capture on start, evaluate one node per cycle, finalize entering DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        osel_d   = osel_q;
        oinv_d   = oinv_q;
        target_d = target_q;
        node_d   = node_q;
        tt_d     = tt_q;
        match_d  = match_q;
        err_d    = err_q;
        finish   = 1'b0;
        f_sel    = osel_q;
        f_inv    = oinv_q;
        f_tgt    = target_q;
        f_n      = n_q;
        fin_v    = '0;

        sat_n  = (int'(num_nodes) > MAX_NODES) ? NW'(MAX_NODES) : num_nodes;
        entry  = prog_q[idx_q[AW-1:0]];
        op_a   = entry[OP_W-1:0];
        op_b   = entry[2*OP_W-1:OP_W];
        op_c   = entry[3*OP_W-1:2*OP_W];
        va     = sel_vec(op_a[SEL_W-1:0], node_q) ^ {TT_W{op_a[SEL_W]}};
        vb     = sel_vec(op_b[SEL_W-1:0], node_q) ^ {TT_W{op_b[SEL_W]}};
        vc     = sel_vec(op_c[SEL_W-1:0], node_q) ^ {TT_W{op_c[SEL_W]}};
        maj    = (va & vb) | (va & vc) | (vb & vc);
        ops_ok = sel_ok(op_a[SEL_W-1:0], idx_q) && sel_ok(op_b[SEL_W-1:0], idx_q)
                 && sel_ok(op_c[SEL_W-1:0], idx_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = sat_n;
                    osel_d   = out_sel;
                    oinv_d   = out_inv;
                    target_d = target;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    f_sel    = out_sel;
                    f_inv    = out_inv;
                    f_tgt    = target;
                    f_n      = sat_n;
                    if (sat_n == '0) begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (!ops_ok) begin
                    err_d   = 1'b1;
                    tt_d    = '0;
                    match_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    node_d[idx_q[AW-1:0]] = maj;
                    idx_d = idx_q + NW'(1);
                    if (idx_q + NW'(1) == n_q) begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output selection sees node_d so the node written this cycle is visible.
        if (finish) begin
            fin_v = sel_vec(f_sel, node_d) ^ {TT_W{f_inv}};
            if (!sel_ok(f_sel, f_n)) begin
                err_d   = 1'b1;
                tt_d    = '0;
                match_d = 1'b0;
            end else begin
                tt_d    = fin_v;
                match_d = (fin_v == f_tgt);
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            osel_q   <= '0;
            oinv_q   <= 1'b0;
            target_q <= '0;
            node_q   <= '0;
            tt_q     <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            osel_q   <= osel_d;
            oinv_q   <= oinv_d;
            target_q <= target_d;
            node_q   <= node_d;
            tt_q     <= tt_d;
            match_q  <= match_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign tt_out = tt_q;
    assign match  = match_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mig_tt_evaluator.sv
// tb/tb_mig_tt_evaluator.sv - directed scoreboard bench for mig_tt_evaluator
module tb_mig_tt_evaluator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic [3:0]  num_nodes = '0;
    logic [3:0]  out_sel = '0;
    logic        out_inv = 1'b0;
    logic [15:0] target = '0;
    logic        start = 1'b0;
    logic        busy, done, match, err;
    logic [15:0] tt_out;

    mig_tt_evaluator #(.NUM_IN(4), .MAX_NODES(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .num_nodes(num_nodes), .out_sel(out_sel),
        .out_inv(out_inv), .target(target), .start(start), .busy(busy),
        .done(done), .tt_out(tt_out), .match(match), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tt;
        logic        m;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] C0 = 4'd0, X0 = 4'd1, X1 = 4'd2, X2 = 4'd3, X3 = 4'd4;

    function automatic logic [3:0] nd(input int k);
        return 4'(5 + k);
    endfunction

    function automatic logic [4:0] op(input logic inv, input logic [3:0] sel);
        return {inv, sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = {c, b, a};
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic kick(input logic [3:0] n, input logic [3:0] osel, input logic oinv,
                        input logic [15:0] tgt, input logic [15:0] e_tt, input logic e_m,
                        input logic e_e, input int lat);
        exp_t e;
        @(negedge clk);
        num_nodes = n;
        out_sel   = osel;
        out_inv   = oinv;
        target    = tgt;
        start     = 1'b1;
        e.tt = e_tt; e.m = e_m; e.e = e_e; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int   k;
        int   bc;
        bit   seen;
        exp_t e;
        k = elapsed; bc = elapsed; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) bc++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_tt"}, 32'(tt_out), 32'(e.tt));
            check({tag, "_match"}, 32'(match), 32'(e.m));
            check({tag, "_err"}, 32'(err), 32'(e.e));
            check({tag, "_latency"}, 32'(k), 32'(e.lat));
            check({tag, "_busy_cycles"}, 32'(bc), 32'(e.lat));
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
            check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int  seen_done;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tt", 32'(tt_out), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // single node MAJ(x0,x1,x2)
        wr(0, op(0, X0), op(0, X1), op(0, X2));
        kick(4'd1, nd(0), 1'b0, 16'hE8E8, 16'hE8E8, 1'b1, 1'b0, 2);
        wait_done("maj3", 0);

        // AND / OR through constants
        wr(0, op(0, X0), op(0, X1), op(0, C0));
        kick(4'd1, nd(0), 1'b0, 16'h0000, 16'h8888, 1'b0, 1'b0, 2);
        wait_done("and", 0);
        wr(0, op(0, X0), op(0, X1), op(1, C0));
        kick(4'd1, nd(0), 1'b0, 16'hEEEE, 16'hEEEE, 1'b1, 1'b0, 2);
        wait_done("or", 0);

        // XOR from three nodes, plain and complemented
        wr(0, op(0, X0), op(1, X1), op(0, C0));
        wr(1, op(1, X0), op(0, X1), op(0, C0));
        wr(2, op(0, nd(0)), op(0, nd(1)), op(1, C0));
        kick(4'd3, nd(2), 1'b0, 16'h6666, 16'h6666, 1'b1, 1'b0, 4);
        wait_done("xor", 0);
        kick(4'd3, nd(2), 1'b1, 16'h6666, 16'h9999, 1'b0, 1'b0, 4);
        wait_done("xnor", 0);

        // intermediate node as output
        kick(4'd3, nd(1), 1'b0, 16'h4444, 16'h4444, 1'b1, 1'b0, 4);
        wait_done("mid_node", 0);

        // zero-node programs
        kick(4'd0, X3, 1'b1, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1);
        wait_done("zero_x3", 0);
        kick(4'd0, nd(0), 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1);
        wait_done("zero_badsel", 0);

        // forward reference, then a legal run clears err
        wr(0, op(0, X0), op(0, X1), op(0, X2));
        wr(1, op(0, X0), op(0, nd(1)), op(0, X2));
        kick(4'd2, nd(1), 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 3);
        wait_done("fwd_ref", 0);
        kick(4'd1, nd(0), 1'b0, 16'hE8E8, 16'hE8E8, 1'b1, 1'b0, 2);
        check("err_cleared_on_start", 32'(err), 32'd0);
        wait_done("after_err", 0);

        // out_sel past the active node count
        kick(4'd1, nd(1), 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2);
        wait_done("osel_past_n", 0);

        // selector beyond the legal range
        wr(0, op(0, 4'd13), op(0, X1), op(0, X2));
        kick(4'd1, nd(0), 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2);
        wait_done("sel_range", 0);

        // 8-node inverter chain, num_nodes saturates from 15 to 8
        wr(0, op(0, X0), op(0, X1), op(0, X2));
        for (int k = 1; k < 8; k++) wr(k, op(1, nd(k - 1)), op(0, C0), op(1, C0));
        kick(4'd15, nd(7), 1'b0, 16'h1717, 16'h1717, 1'b1, 1'b0, 9);
        wait_done("chain_sat", 0);

        // cfg_we and start while busy are ignored (XOR program rebuilt first)
        wr(0, op(0, X0), op(1, X1), op(0, C0));
        wr(1, op(1, X0), op(0, X1), op(0, C0));
        wr(2, op(0, nd(0)), op(0, nd(1)), op(1, C0));
        kick(4'd3, nd(2), 1'b0, 16'h6666, 16'h6666, 1'b1, 1'b0, 4);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = {op(0, C0), op(0, nd(1)), op(0, nd(0))};
        start = 1'b1; num_nodes = 4'd0; out_sel = X3; out_inv = 1'b1;
        @(posedge clk);
        #1 begin cfg_we = 1'b0; start = 1'b0; end
        wait_done("busy_ignore", 1);
        kick(4'd3, nd(2), 1'b0, 16'h6666, 16'h6666, 1'b1, 1'b0, 4);
        wait_done("busy_ignore_rerun", 0);

        // write and start in the same cycle: evaluation sees the new entry
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = {op(0, C0), op(0, X1), op(0, X0)};
        num_nodes = 4'd1; out_sel = nd(0); out_inv = 1'b0; target = 16'h8888; start = 1'b1;
        sb.push_back('{tt: 16'h8888, m: 1'b1, e: 1'b0, lat: 2});
        @(posedge clk);
        #1 begin cfg_we = 1'b0; start = 1'b0; end
        wait_done("same_cycle_wr", 0);

        // async reset in the middle of an 8-node evaluation
        wr(0, op(0, X0), op(0, X1), op(0, X2));
        for (int k = 1; k < 8; k++) wr(k, op(1, nd(k - 1)), op(0, C0), op(1, C0));
        @(negedge clk);
        num_nodes = 4'd8; out_sel = nd(7); out_inv = 1'b0; target = 16'h1717; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tt", 32'(tt_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("no_done_after_reset", 32'(seen_done), 32'd0);

        // recovery after reset
        wr(0, op(0, X0), op(0, X1), op(0, X2));
        kick(4'd1, nd(0), 1'b1, 16'h1717, 16'h1717, 1'b1, 1'b0, 2);
        wait_done("post_reset", 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
